// File: rtl/data_ram_be_pkg.sv
// Shared size codes, FSM states and helpers for the byte-enabled data memory.
package data_ram_be_pkg;

  typedef enum logic [1:0] {
    MEM_SZ_B = 2'b00,
    MEM_SZ_H = 2'b01,
    MEM_SZ_W = 2'b10,
    MEM_SZ_D = 2'b11
  } mem_size_e;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } ram_state_e;

  function automatic int unsigned size_bytes(input logic [1:0] sz);
    return 32'd1 << sz;
  endfunction

endpackage

// File: rtl/data_ram_be_lane_align.sv
// Combinational lane steering: store strobes/shifted data, load extraction with sign/zero extension.
module mem_lane_align
  import data_ram_be_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned NB    = DATA_W / 8,
  localparam int unsigned OFF   = $clog2(NB)
) (
  input  logic [1:0]        st_size,
  input  logic [OFF-1:0]    st_off,
  input  logic [DATA_W-1:0] st_data,
  output logic [NB-1:0]     st_strb,
  output logic [DATA_W-1:0] st_wdata,
  input  logic [DATA_W-1:0] ld_word,
  input  logic [OFF-1:0]    ld_off,
  input  logic [1:0]        ld_size,
  input  logic              ld_uns,
  output logic [DATA_W-1:0] ld_ext
);

  logic [DATA_W-1:0] sh;
  logic              sign;
  logic              fill;
  int unsigned       nbits;

  always_comb begin
    st_strb  = NB'(((32'd1 << size_bytes(st_size)) - 32'd1) << st_off);
    st_wdata = st_data << {st_off, 3'b000};
  end

  always_comb begin
    sh    = ld_word >> {ld_off, 3'b000};
    nbits = size_bytes(ld_size) << 3;
    if (nbits > DATA_W) nbits = DATA_W;
    sign = sh[DATA_W-1];
    case (ld_size)
      MEM_SZ_B: sign = sh[7];
      MEM_SZ_H: sign = sh[15];
      MEM_SZ_W: sign = sh[31];
      default:  sign = sh[DATA_W-1];
    endcase
    fill   = ~ld_uns & sign;
    ld_ext = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      ld_ext[i] = (i < nbits) ? sh[i] : fill;
    end
  end

endmodule

// File: rtl/data_ram_be.sv
// MEM-stage data memory: one load and one store port, byte lanes, error flags, write-first merge, zero-init FSM.
module data_ram_be
  import data_ram_be_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter bit                INIT_ZERO = 1'b1
) (
  input  logic              clk_100MHz,
  input  logic              arst_n,
  output logic              ready_o,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [1:0]        ld_size_i,
  input  logic              ld_uns_i,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              ld_valid_o,
  output logic              ld_err_o,
  input  logic              st_req_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [1:0]        st_size_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic              st_err_o
);

  localparam int unsigned      NB        = DATA_W / 8;
  localparam int unsigned      OFF       = $clog2(NB);
  localparam int unsigned      IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  SPAN      = (ADDR_W+1)'(DEPTH * NB);
  localparam logic [IDX_W-1:0] LAST      = IDX_W'(DEPTH - 1);
  localparam ram_state_e       RST_STATE = INIT_ZERO ? S_INIT : S_RUN;

  function automatic logic acc_bad(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
    logic [ADDR_W-1:0] rel;
    logic [ADDR_W-1:0] mask;
    rel  = a - BASE_ADDR;
    mask = ADDR_W'(size_bytes(sz) - 1);
    return (a < BASE_ADDR) || ({1'b0, rel} >= SPAN) || ((a & mask) != '0) ||
           ((sz == MEM_SZ_D) && (DATA_W == 32));
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  ram_state_e        state;
  logic [IDX_W-1:0]  cnt;

  logic              ld_acc, st_acc, ld_bad, st_bad, st_we;
  logic [IDX_W-1:0]  ld_idx, st_idx;
  logic [NB-1:0]     st_strb;
  logic [DATA_W-1:0] st_wdata, ld_word, ld_merged, ld_ext;

  assign ld_acc = ld_req_i & ready_o;
  assign st_acc = st_req_i & ready_o;
  assign ld_bad = acc_bad(ld_addr_i, ld_size_i);
  assign st_bad = acc_bad(st_addr_i, st_size_i);
  assign st_we  = st_acc & ~st_bad;
  assign ld_idx = IDX_W'((ld_addr_i - BASE_ADDR) >> OFF);
  assign st_idx = IDX_W'((st_addr_i - BASE_ADDR) >> OFF);
  assign ld_word = mem[ld_idx];

  // Write-first: strobed lanes of a same-index store override the stored word for the load.
  always_comb begin
    ld_merged = ld_word;
    for (int unsigned b = 0; b < NB; b++) begin
      if (st_we && (st_idx == ld_idx) && st_strb[b]) ld_merged[b*8 +: 8] = st_wdata[b*8 +: 8];
    end
  end

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .st_size  (st_size_i),
    .st_off   (st_addr_i[OFF-1:0]),
    .st_data  (st_data_i),
    .st_strb  (st_strb),
    .st_wdata (st_wdata),
    .ld_word  (ld_merged),
    .ld_off   (ld_addr_i[OFF-1:0]),
    .ld_size  (ld_size_i),
    .ld_uns   (ld_uns_i),
    .ld_ext   (ld_ext)
  );

  always_ff @(posedge clk_100MHz) begin
    if (state == S_INIT) begin
      mem[cnt] <= '0;
    end else if (st_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (st_strb[b]) mem[st_idx][b*8 +: 8] <= st_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state      <= RST_STATE;
      cnt        <= '0;
      ready_o    <= 1'b0;
      ld_data_o  <= '0;
      ld_valid_o <= 1'b0;
      ld_err_o   <= 1'b0;
      st_err_o   <= 1'b0;
    end else begin
      ld_valid_o <= ld_acc;
      ld_err_o   <= ld_acc & ld_bad;
      st_err_o   <= st_acc & st_bad;
      if (ld_acc) ld_data_o <= ld_bad ? '0 : ld_ext;
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state   <= S_RUN;
            ready_o <= 1'b1;
          end
        end
        default: ready_o <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_be.sv
// Directed, table-driven bench for data_ram_be (32-bit and 64-bit instances, DEPTH=16).
module tb_data_ram_be;

  logic clk, arst_n;

  logic        r32_ready, r32_ld_req, r32_ld_uns, r32_ld_valid, r32_ld_err, r32_st_req, r32_st_err;
  logic [31:0] r32_ld_addr, r32_st_addr, r32_ld_data, r32_st_data;
  logic [1:0]  r32_ld_size, r32_st_size;

  logic        r64_ready, r64_ld_req, r64_ld_uns, r64_ld_valid, r64_ld_err, r64_st_req, r64_st_err;
  logic [31:0] r64_ld_addr, r64_st_addr;
  logic [63:0] r64_ld_data, r64_st_data;
  logic [1:0]  r64_ld_size, r64_st_size;

  int checks = 0;
  int errors = 0;

  data_ram_be #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .BASE_ADDR(32'h0), .INIT_ZERO(1'b1)) dut32 (
    .clk_100MHz(clk), .arst_n(arst_n), .ready_o(r32_ready),
    .ld_req_i(r32_ld_req), .ld_addr_i(r32_ld_addr), .ld_size_i(r32_ld_size), .ld_uns_i(r32_ld_uns),
    .ld_data_o(r32_ld_data), .ld_valid_o(r32_ld_valid), .ld_err_o(r32_ld_err),
    .st_req_i(r32_st_req), .st_addr_i(r32_st_addr), .st_size_i(r32_st_size), .st_data_i(r32_st_data),
    .st_err_o(r32_st_err)
  );

  data_ram_be #(.DATA_W(64), .DEPTH(16), .ADDR_W(32), .BASE_ADDR(32'h0), .INIT_ZERO(1'b1)) dut64 (
    .clk_100MHz(clk), .arst_n(arst_n), .ready_o(r64_ready),
    .ld_req_i(r64_ld_req), .ld_addr_i(r64_ld_addr), .ld_size_i(r64_ld_size), .ld_uns_i(r64_ld_uns),
    .ld_data_o(r64_ld_data), .ld_valid_o(r64_ld_valid), .ld_err_o(r64_ld_err),
    .st_req_i(r64_st_req), .st_addr_i(r64_st_addr), .st_size_i(r64_st_size), .st_data_i(r64_st_data),
    .st_err_o(r64_st_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ld;
    logic [31:0] la;
    logic [1:0]  ls;
    logic        lu;
    logic        st;
    logic [31:0] sa;
    logic [1:0]  ss;
    logic [31:0] sd;
    logic        ev;
    logic        ele;
    logic [31:0] ed;
    logic        ese;
  } vec_t;

  localparam int NV = 19;
  vec_t v[NV];

  function automatic vec_t mk(input string n, input logic ld, input logic [31:0] la, input logic [1:0] ls,
                              input logic lu, input logic st, input logic [31:0] sa, input logic [1:0] ss,
                              input logic [31:0] sd, input logic ev, input logic ele, input logic [31:0] ed,
                              input logic ese);
    vec_t r;
    r.name = n; r.ld = ld; r.la = la; r.ls = ls; r.lu = lu;
    r.st = st; r.sa = sa; r.ss = ss; r.sd = sd;
    r.ev = ev; r.ele = ele; r.ed = ed; r.ese = ese;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive32(input vec_t x);
    r32_ld_req = x.ld; r32_ld_addr = x.la; r32_ld_size = x.ls; r32_ld_uns = x.lu;
    r32_st_req = x.st; r32_st_addr = x.sa; r32_st_size = x.ss; r32_st_data = x.sd;
  endtask

  task automatic idle_all();
    r32_ld_req = 0; r32_ld_addr = '0; r32_ld_size = 2'b10; r32_ld_uns = 0;
    r32_st_req = 0; r32_st_addr = '0; r32_st_size = 2'b10; r32_st_data = '0;
    r64_ld_req = 0; r64_ld_addr = '0; r64_ld_size = 2'b11; r64_ld_uns = 0;
    r64_st_req = 0; r64_st_addr = '0; r64_st_size = 2'b11; r64_st_data = '0;
  endtask

  // Single 32-bit request applied at a negedge, checked at the following negedge.
  task automatic op32(input vec_t x);
    drive32(x);
    @(negedge clk);
    chk({x.name, ".valid"}, 64'(r32_ld_valid), 64'(x.ev));
    chk({x.name, ".data"}, 64'(r32_ld_data), 64'(x.ed));
    idle_all();
  endtask

  task automatic op64(input string nm, input logic ld, input logic [31:0] la, input logic [1:0] ls,
                      input logic lu, input logic st, input logic [31:0] sa, input logic [1:0] ss,
                      input logic [63:0] sd, input logic ev, input logic ele, input logic [63:0] ed,
                      input logic ese);
    r64_ld_req = ld; r64_ld_addr = la; r64_ld_size = ls; r64_ld_uns = lu;
    r64_st_req = st; r64_st_addr = sa; r64_st_size = ss; r64_st_data = sd;
    @(negedge clk);
    chk({nm, ".valid"}, 64'(r64_ld_valid), 64'(ev));
    chk({nm, ".ld_err"}, 64'(r64_ld_err), 64'(ele));
    chk({nm, ".data"}, r64_ld_data, ed);
    chk({nm, ".st_err"}, 64'(r64_st_err), 64'(ese));
    idle_all();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      n++;
      if (r32_ready) break;
    end
    if (!r32_ready) n = -1;
  endtask

  initial begin
    int n;
    logic pulsed;

    v[0]  = mk("lw_last_word", 1, 32'h3C, 2'b10, 0, 0, 32'h0,  2'b10, 32'h0,        1, 0, 32'h00000000, 0);
    v[1]  = mk("sw_8",         0, 32'h0,  2'b10, 0, 1, 32'h8,  2'b10, 32'hDEADBEEF, 0, 0, 32'h00000000, 0);
    v[2]  = mk("lb_9",         1, 32'h9,  2'b00, 0, 0, 32'h0,  2'b10, 32'h0,        1, 0, 32'hFFFFFFBE, 0);
    v[3]  = mk("lbu_9",        1, 32'h9,  2'b00, 1, 0, 32'h0,  2'b10, 32'h0,        1, 0, 32'h000000BE, 0);
    v[4]  = mk("lh_a",         1, 32'hA,  2'b01, 0, 0, 32'h0,  2'b10, 32'h0,        1, 0, 32'hFFFFDEAD, 0);
    v[5]  = mk("lhu_a",        1, 32'hA,  2'b01, 1, 0, 32'h0,  2'b10, 32'h0,        1, 0, 32'h0000DEAD, 0);
    v[6]  = mk("merge_sb_lw",  1, 32'h8,  2'b10, 0, 1, 32'h9,  2'b00, 32'hFFFFFF11, 1, 0, 32'hDEAD11EF, 0);
    v[7]  = mk("lw_after_sb",  1, 32'h8,  2'b10, 0, 0, 32'h0,  2'b10, 32'h0,        1, 0, 32'hDEAD11EF, 0);
    v[8]  = mk("lw_misalign",  1, 32'h6,  2'b10, 0, 0, 32'h0,  2'b10, 32'h0,        1, 1, 32'h00000000, 0);
    v[9]  = mk("sh_misalign",  0, 32'h0,  2'b10, 0, 1, 32'h3,  2'b01, 32'h0000AAAA, 0, 0, 32'h00000000, 1);
    v[10] = mk("sw_range",     0, 32'h0,  2'b10, 0, 1, 32'h40, 2'b10, 32'h00000055, 0, 0, 32'h00000000, 1);
    v[11] = mk("lw_readback",  1, 32'h8,  2'b10, 0, 0, 32'h0,  2'b10, 32'h0,        1, 0, 32'hDEAD11EF, 0);
    v[12] = mk("ld_on_32",     1, 32'h0,  2'b11, 0, 0, 32'h0,  2'b10, 32'h0,        1, 1, 32'h00000000, 0);
    v[13] = mk("merge_sh_hi",  1, 32'hC,  2'b10, 0, 1, 32'hE,  2'b01, 32'h00001234, 1, 0, 32'h12340000, 0);
    v[14] = mk("diff_index",   1, 32'h8,  2'b10, 0, 1, 32'h0,  2'b00, 32'h00000080, 1, 0, 32'hDEAD11EF, 0);
    v[15] = mk("lb_0_neg",     1, 32'h0,  2'b00, 0, 0, 32'h0,  2'b10, 32'h0,        1, 0, 32'hFFFFFF80, 0);
    v[16] = mk("lhu_e",        1, 32'hE,  2'b01, 1, 0, 32'h0,  2'b10, 32'h0,        1, 0, 32'h00001234, 0);
    v[17] = mk("both_bad",     1, 32'h44, 2'b10, 0, 1, 32'h5,  2'b10, 32'h0,        1, 1, 32'h00000000, 1);
    v[18] = mk("idle_hold",    0, 32'h0,  2'b10, 0, 0, 32'h0,  2'b10, 32'h0,        0, 0, 32'h00000000, 0);

    idle_all();
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.ready32", 64'(r32_ready), 0);
    chk("rst.ready64", 64'(r64_ready), 0);
    chk("rst.ld_data", 64'(r32_ld_data), 0);
    chk("rst.pulses", {61'b0, r32_ld_valid, r32_ld_err, r32_st_err}, 0);

    // Init: requests must be ignored until ready.
    arst_n = 1'b1;
    r32_ld_req = 1; r32_ld_addr = 32'h6; r32_st_req = 1; r32_st_addr = 32'h41;
    pulsed = 0; n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      n++;
      pulsed = pulsed | r32_ld_valid | r32_ld_err | r32_st_err;
      if (r32_ready) break;
    end
    idle_all();
    if (!r32_ready) n = -1;
    chk("init.cycles", 64'(n), 64'd16);
    chk("init.no_pulse", 64'(pulsed), 0);
    chk("init.ready64", 64'(r64_ready), 1);

    // Table: back-to-back vectors, each checked one cycle after its accepting edge.
    drive32(v[0]);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk({v[i].name, ".valid"}, 64'(r32_ld_valid), 64'(v[i].ev));
      chk({v[i].name, ".ld_err"}, 64'(r32_ld_err), 64'(v[i].ele));
      chk({v[i].name, ".data"}, 64'(r32_ld_data), 64'(v[i].ed));
      chk({v[i].name, ".st_err"}, 64'(r32_st_err), 64'(v[i].ese));
      if (i + 1 < NV) drive32(v[i+1]);
      else idle_all();
    end
    @(negedge clk);
    chk("pulse_clear", {61'b0, r32_ld_valid, r32_ld_err, r32_st_err}, 0);

    // 64-bit lanes.
    op64("sd_10",    0, 32'h0,  2'b11, 0, 1, 32'h10, 2'b11, 64'h0123456789ABCDEF, 0, 0, 64'h0, 0);
    op64("lw_14",    1, 32'h14, 2'b10, 0, 0, 32'h0,  2'b11, 64'h0, 1, 0, 64'h0000000001234567, 0);
    op64("ld_10",    1, 32'h10, 2'b11, 0, 0, 32'h0,  2'b11, 64'h0, 1, 0, 64'h0123456789ABCDEF, 0);
    op64("lw_10",    1, 32'h10, 2'b10, 0, 0, 32'h0,  2'b11, 64'h0, 1, 0, 64'hFFFFFFFF89ABCDEF, 0);
    op64("ld_mis",   1, 32'h14, 2'b11, 0, 0, 32'h0,  2'b11, 64'h0, 1, 1, 64'h0, 0);
    op64("lbu_17",   1, 32'h17, 2'b00, 1, 0, 32'h0,  2'b11, 64'h0, 1, 0, 64'h0000000000000001, 0);
    op64("lh_12",    1, 32'h12, 2'b01, 0, 0, 32'h0,  2'b11, 64'h0, 1, 0, 64'hFFFFFFFFFFFF89AB, 0);
    op64("sd_range", 0, 32'h0,  2'b11, 0, 1, 32'h80, 2'b11, 64'h1, 0, 0, 64'hFFFFFFFFFFFF89AB, 1);

    // Reset during init restarts the clear from word 0.
    op32(mk("pre_rst_lw", 1, 32'h8, 2'b10, 0, 0, 32'h0, 2'b10, 32'h0, 1, 0, 32'hDEAD11EF, 0));
    arst_n = 1'b0;
    #1;
    chk("async_rst.data", 64'(r32_ld_data), 0);
    chk("async_rst.ready", 64'(r32_ready), 0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_init.ready", 64'(r32_ready), 0);
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    wait_ready(n);
    chk("reinit.cycles", 64'(n), 64'd16);
    op32(mk("cleared_8", 1, 32'h8, 2'b10, 0, 0, 32'h0, 2'b10, 32'h0, 1, 0, 32'h0, 0));
    op32(mk("cleared_0", 1, 32'h0, 2'b10, 0, 0, 32'h0, 2'b10, 32'h0, 1, 0, 32'h0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
